// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer and its step unit.
package shift_seq_pkg;

  localparam int unsigned WIDTH_C = 16;

  typedef enum logic [1:0] {
    OP_PASS,
    OP_LSL,
    OP_LSR,
    OP_ASR
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-position 16-bit shift unit: one step of LSL/LSR/ASR, plus the bit shifted out.
module shifter
  import shift_seq_pkg::*;
(
  input  logic [WIDTH_C-1:0] din,
  input  shift_op_t          code,
  output logic [WIDTH_C-1:0] dout,
  output logic               cout
);

  always_comb begin
    dout = din;
    cout = 1'b0;
    case (code)
      OP_LSL: begin
        dout = {din[WIDTH_C-2:0], 1'b0};
        cout = din[WIDTH_C-1];
      end
      OP_LSR: begin
        dout = {1'b0, din[WIDTH_C-1:1]};
        cout = din[0];
      end
      OP_ASR: begin
        dout = {din[WIDTH_C-1], din[WIDTH_C-1:1]};
        cout = din[0];
      end
      default: begin
        dout = din;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-position shift controller driving a single-step shifter once per cycle.
// Optional carry_out port and register enabled by defining SHIFT_SEQ_CARRY_EN.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [1:0]       req_op,
  input  logic [AMT_W-1:0] req_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef SHIFT_SEQ_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  if (WIDTH != WIDTH_C) begin : g_bad_width
    $error("shift_sequencer: WIDTH must be 16");
  end

  seq_state_t       state, next_state;
  logic [WIDTH-1:0] work;
  shift_op_t        op_reg;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] step_out;
  logic             step_carry;
  logic             accept;

  shifter u_shifter (
    .din  (work),
    .code (op_reg),
    .dout (step_out),
    .cout (step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          // Zero amount or pass op skips the shift phase entirely.
          if (req_amt == '0 || shift_op_t'(req_op) == OP_PASS) next_state = S_DONE;
          else                                               next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (count == AMT_W'(1)) next_state = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      op_reg <= OP_PASS;
      count  <= '0;
    end else if (accept) begin
      work   <= req_data;
      op_reg <= shift_op_t'(req_op);
      count  <= req_amt;
    end else if (state == S_SHIFT) begin
      work  <= step_out;
      count <= count - AMT_W'(1);
    end
  end

  assign rsp_data = work;

`ifdef SHIFT_SEQ_CARRY_EN
  logic carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 carry_q <= 1'b0;
    else if (accept)            carry_q <= 1'b0;
    else if (state == S_SHIFT)  carry_q <= step_carry;
  end

  assign carry_out = carry_q;
`else
  logic unused_carry;
  assign unused_carry = step_carry;
`endif

endmodule
